// File: rtl/calc_sequencer.sv
// calc_sequencer
// Multi-cycle sequencer for the calculator add/subtract datapath. Accepts one
// funct command plus operands in IDLE, then runs ADD/SUB in one step or
// MULT/DIV in WIDTH steps (shift-add multiply, restoring divide). It also
// keeps the "previous result" register used by the ToPrev opcodes.
//
// Ports:
//   clk, rst_n       system clock (rising edge), async active-low reset
//   start            command request, sampled only in IDLE
//   funct[2:0]       funct[2]=1: X=operand_a, Y=operand_b
//                    funct[2]=0: X=prev_value, Y=operand_a
//                    funct[1:0]: 00 add, 01 sub, 10 mul, 11 div (X op Y)
//   operand_a/b      operands
//   clear_prev       zeroes prev_value, honoured only in IDLE
//   busy             high whenever not in IDLE
//   done             one-cycle pulse in FINISH; result and flags valid
//   result           registered result
//   prev_value       stored previous result
//   overflow         carry / borrow / product truncation
//   div_by_zero      divisor was zero
//
// state  | meaning
// IDLE   | waiting for start; clear_prev honoured here
// CALC   | iterate datapath steps, then one commit edge into FINISH
// FINISH | done pulse; returns to IDLE on the next edge

module calc_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       funct,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             clear_prev,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] prev_value,
   output logic             overflow,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FINISH} seqState_t;

   seqState_t        state;
   logic [1:0]       opReg;
   logic [WIDTH-1:0] xReg;
   logic [WIDTH-1:0] yReg;
   logic [WIDTH-1:0] accHi;    // product high half / divide remainder
   logic [WIDTH-1:0] mq;       // multiplier->product low / dividend->quotient / sum
   logic             carryReg;
   logic [CNT_W-1:0] iterCnt;
   logic [CNT_W-1:0] lastStep;

   logic [WIDTH-1:0] xSel;
   logic [WIDTH-1:0] ySel;
   logic [WIDTH:0]   addSub;
   logic [WIDTH:0]   mulSum;
   logic [WIDTH:0]   divShift;
   logic [WIDTH-1:0] divDiff;
   logic             divGe;
   logic             isDivZero;

   // A clear on the accept edge must already apply to the ToPrev operand.
   assign xSel = funct[2] ? operand_a : (clear_prev ? '0 : prev_value);
   assign ySel = funct[2] ? operand_b : operand_a;

   // MSB of the zero-extended add/sub is carry out for add and borrow for sub.
   assign addSub   = opReg[0] ? ({1'b0, xReg} - {1'b0, yReg})
                              : ({1'b0, xReg} + {1'b0, yReg});
   assign mulSum   = {1'b0, accHi} + (mq[0] ? {1'b0, xReg} : '0);
   assign divShift = {accHi, mq[WIDTH-1]};
   assign divGe    = (divShift >= {1'b0, yReg});
   // When divGe holds the difference is below the divisor, so WIDTH bits suffice.
   assign divDiff  = divShift[WIDTH-1:0] - yReg;

   assign lastStep  = opReg[1] ? CNT_W'(WIDTH) : CNT_W'(1);
   assign isDivZero = (opReg == 2'b11) && (yReg == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         opReg       <= '0;
         xReg        <= '0;
         yReg        <= '0;
         accHi       <= '0;
         mq          <= '0;
         carryReg    <= 1'b0;
         iterCnt     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         result      <= '0;
         prev_value  <= '0;
         overflow    <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clear_prev) prev_value <= '0;
               if (start) begin
                  opReg    <= funct[1:0];
                  xReg     <= xSel;
                  yReg     <= ySel;
                  accHi    <= '0;
                  carryReg <= 1'b0;
                  // Divide shifts the dividend out of mq; multiply shifts the multiplier.
                  mq       <= (funct[1:0] == 2'b11) ? xSel : ySel;
                  iterCnt  <= '0;
                  busy     <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               if (iterCnt == lastStep) begin
                  result      <= mq;
                  overflow    <= opReg[1] ? (!opReg[0] && (accHi != '0)) : carryReg;
                  div_by_zero <= isDivZero;
                  if (!isDivZero) prev_value <= mq;
                  done        <= 1'b1;
                  state       <= FINISH;
               end else begin
                  iterCnt <= iterCnt + 1'b1;
                  case (opReg)
                     2'b10: begin
                        accHi <= mulSum[WIDTH:1];
                        mq    <= {mulSum[0], mq[WIDTH-1:1]};
                     end
                     2'b11: begin
                        accHi <= divGe ? divDiff : divShift[WIDTH-1:0];
                        mq    <= {mq[WIDTH-2:0], divGe};
                     end
                     default: begin
                        mq       <= addSub[WIDTH-1:0];
                        carryReg <= addSub[WIDTH];
                     end
                  endcase
               end
            end
            FINISH: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   funct = 3'b100;
   logic [W-1:0] operand_a = '0;
   logic [W-1:0] operand_b = '0;
   logic         clear_prev = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic [W-1:0] prev_value;
   logic         overflow;
   logic         div_by_zero;

   calc_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
      .operand_a(operand_a), .operand_b(operand_b), .clear_prev(clear_prev),
      .busy(busy), .done(done), .result(result), .prev_value(prev_value),
      .overflow(overflow), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] res;
      logic         ovf;
      logic         dbz;
      logic [W-1:0] prev;
      int           lat;
   } exp_t;

   exp_t         sbq[$];
   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] modelPrev = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference arithmetic written directly from the opcode table.
   task automatic pushExpected(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic clr);
      exp_t        e;
      logic [7:0]  x, y, p;
      logic [15:0] prod;
      logic [8:0]  sum;
      p = clr ? 8'd0 : modelPrev;
      x = f[2] ? a : p;
      y = f[2] ? b : a;
      e.dbz = 1'b0;
      e.ovf = 1'b0;
      case (f[1:0])
         2'b00: begin sum = x + y; e.res = sum[7:0]; e.ovf = sum[8]; end
         2'b01: begin e.res = x - y; e.ovf = (x < y); end
         2'b10: begin prod = x * y; e.res = prod[7:0]; e.ovf = (prod[15:8] != 0); end
         default: begin
            if (y == 0) begin e.res = 8'hFF; e.dbz = 1'b1; end
            else e.res = x / y;
         end
      endcase
      e.prev = e.dbz ? p : e.res;
      e.lat = f[1] ? W + 1 : 2;
      modelPrev = e.prev;
      sbq.push_back(e);
   endtask

   // Called #1 after the accept edge; counts edges until done is seen.
   task automatic waitDone(input string tag);
      exp_t e;
      int   lat;
      lat = 0;
      while (lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (done) break;
         check({tag, "_busy"}, busy, 1);
      end
      check({tag, "_sb_nonempty"}, (sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
         e = sbq.pop_front();
         check({tag, "_latency"}, lat, e.lat);
         check({tag, "_result"}, result, e.res);
         check({tag, "_overflow"}, overflow, e.ovf);
         check({tag, "_dbz"}, div_by_zero, e.dbz);
         check({tag, "_prev"}, prev_value, e.prev);
      end
   endtask

   task automatic runOp(input string tag, input logic [2:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic clr);
      @(negedge clk);
      funct = f; operand_a = a; operand_b = b; clear_prev = clr; start = 1'b1;
      pushExpected(f, a, b, clr);
      @(posedge clk); #1;
      start = 1'b0; clear_prev = 1'b0;
      // Scribble the inputs: the latched command must not change.
      operand_a = ~a; operand_b = ~b; funct = ~f;
      waitDone(tag);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_prev", prev_value, 0);
      check("rst_flags", {overflow, div_by_zero}, 0);
      @(negedge clk); rst_n = 1'b1;

      runOp("add_carry", 3'b100, 8'd200, 8'd100, 1'b0);
      runOp("add_prev", 3'b000, 8'd7, 8'd0, 1'b0);
      runOp("sub_borrow", 3'b101, 8'd5, 8'd9, 1'b0);

      @(negedge clk); clear_prev = 1'b1;
      @(posedge clk); #1;
      clear_prev = 1'b0; modelPrev = '0;
      check("clear_prev", prev_value, 0);

      runOp("sub_prev", 3'b001, 8'd0, 8'd0, 1'b0);
      runOp("mul", 3'b110, 8'd13, 8'd11, 1'b0);
      runOp("mul_ovf", 3'b110, 8'd16, 8'd16, 1'b0);
      runOp("div", 3'b111, 8'd100, 8'd7, 1'b0);
      runOp("div_zero", 3'b111, 8'd9, 8'd0, 1'b0);
      runOp("clr_and_start", 3'b000, 8'd3, 8'd0, 1'b1);
      runOp("set_prev", 3'b100, 8'd100, 8'd100, 1'b0);

      // start held high: second op accepted only after FINISH returns to IDLE.
      @(negedge clk);
      funct = 3'b011; operand_a = 8'd8; start = 1'b1;
      pushExpected(3'b011, 8'd8, 8'd0, 1'b0);
      @(posedge clk); #1;
      operand_a = 8'd5; clear_prev = 1'b1;
      waitDone("held1");
      clear_prev = 1'b0;
      @(posedge clk); #1;
      check("held_idle_gap", busy, 0);
      pushExpected(3'b011, 8'd5, 8'd0, 1'b0);
      @(posedge clk); #1;
      check("held_reaccept", busy, 1);
      start = 1'b0;
      waitDone("held2");
      @(posedge clk); #1;
      check("held2_idle", busy, 0);

      // Async reset in the middle of a multiply.
      @(negedge clk);
      funct = 3'b110; operand_a = 8'd13; operand_b = 8'd11; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_result", result, 0);
      check("arst_prev", prev_value, 0);
      check("arst_flags", {overflow, div_by_zero}, 0);
      modelPrev = '0;
      @(negedge clk); rst_n = 1'b1;

      runOp("post_rst_add", 3'b100, 8'd1, 8'd2, 1'b0);
      runOp("mul_prev", 3'b010, 8'd100, 8'd0, 1'b0);

      check("sb_drained", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Multi-cycle sequencer for the calculator's add/subtract datapath. It accepts one 3-bit funct command plus operands and steps the shared adder/subtractor to complete ADD/SUB in one step, or MULT/DIV over WIDTH steps (shift-add / restoring divide).
- It holds the "previous result" register used by the ToPrev opcodes.
- It sits between the command front end and the result register / display path.

Parameters:
- WIDTH, 8, operand/result width in bits; all arithmetic is unsigned.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  command request; sampled only in IDLE.
- funct  input  3  opcode: 100 ADD, 101 SUB, 110 MULT, 111 DIV, 000 ADDToPrev, 001 SUBToPrev, 010 MULTWithPrev, 011 DIVByPrev.
- operand_a  input  WIDTH  first operand (direct ops) / sole operand (ToPrev ops).
- operand_b  input  WIDTH  second operand (direct ops only; ignored for ToPrev).
- clear_prev  input  1  clears prev register; honoured only in IDLE.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result and flags valid.
- result  output  WIDTH  registered result.
- prev_value  output  WIDTH  stored previous result.
- overflow  output  1  carry / borrow / product truncation flag.
- div_by_zero  output  1  divisor was zero.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, overflow, div_by_zero = 0; result, prev_value, iteration counter and internal working registers = 0. Reset mid-operation aborts the operation; no partial update survives.
- Operand selection (funct[2]):
  - funct[2]=1: X=operand_a, Y=operand_b.
  - funct[2]=0: X=prev_value, Y=operand_a.
  - funct[1:0]: 00 add, 01 sub, 10 mul, 11 div, computing X op Y.
- FSM has three states: IDLE, CALC, FINISH.
  - IDLE: on an edge with start=1, latch funct, X, Y, clear the iteration counter, and go to CALC (the accept edge, N).
  - CALC, add/sub: one edge computes X+Y or X-Y, then go to FINISH.
  - CALC, mul/div: WIDTH edges, one bit per edge, then go to FINISH.
  - FINISH: done=1 for exactly this cycle; the next edge returns to IDLE.
- Latency:
  - add/sub: done is high in the cycle after edge N+2.
  - mul/div: done is high in the cycle after edge N+WIDTH+1.
  - Earliest next accept is the edge ending the FINISH cycle + 1, i.e. start must be seen in IDLE.
- start while busy (CALC or FINISH) is ignored, not queued. Operand/funct changes after the accept edge have no effect.
- result, overflow and div_by_zero update on the edge entering FINISH and hold until the next such edge.
- Arithmetic rules:
  - add: result = (X+Y) mod 2^WIDTH; overflow = carry out.
  - sub: result = (X-Y) mod 2^WIDTH; overflow = borrow (X<Y).
  - mul: result = low WIDTH bits of X*Y; overflow = 1 if any high WIDTH bits are nonzero.
  - div: result = floor(X/Y); overflow = 0. If Y=0: result = all ones, div_by_zero=1, and the bench still sees the full WIDTH-step latency.
- prev_value:
  - Loads result on the edge entering FINISH for every op with div_by_zero=0.
  - On a divide by zero, prev_value is unchanged.
- clear_prev in IDLE zeroes prev_value at that edge. If clear_prev and start fall on the same edge, the accepted ToPrev op uses X=0. clear_prev outside IDLE is ignored.
- funct values are all defined; there are no illegal opcodes.

Test Plan (WIDTH=8):
1. ADD a=200 b=100 → result=44, overflow=1, done one cycle after edge N+2, prev_value=44. Then ADDToPrev a=7 → result=51, overflow=0.
2. SUB a=5 b=9 → result=252, overflow=1. Then clear_prev in IDLE → prev_value=0; SUBToPrev a=0 → result=0, overflow=0.
3. MULT a=13 b=11 → result=143, overflow=0, done exactly one cycle after edge N+9. MULT a=16 b=16 → result=0, overflow=1.
4. DIV a=100 b=7 → result=14. DIV a=9 b=0 → result=255, div_by_zero=1, prev_value remains 14, latency still 9 edges.
5. With prev_value=200, DIVByPrev a=8 → result=25. Hold start=1 continuously → a new op is accepted only after returning to IDLE, never during CALC/FINISH.
6. Assert rst_n=0 on edge N+4 of a MULT → busy, done, result, prev_value, flags = 0 immediately (async). After release, an ADD 1+2 → result=3, normal latency.
